// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants and enums for the data-RAM write-port
//               arbiter. It holds the well-known word indices of the game
//               registers, the grant-owner encoding and the arbiter state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Word indices inside the data RAM
    localparam int OFFSET_W = 0;
    localparam int KB_W     = 1;
    localparam int JUEGO_W  = 2;
    localparam int END_W    = 3;
    localparam int COIN_W   = 5;

    // Which source owns the RAM write port in the current cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CPU  = 2'd1,
        SRC_KB   = 2'd2,
        SRC_EXT  = 2'd3
    } arb_src_t;

    // IDLE: nothing besides the CPU wants the port; PEND: KB/EXT waiting
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_kb_code_latch.sv
// ============================================================================
// Module      : kb_code_latch
// Description : One-deep holding buffer for keyboard scan codes. A new code
//               always replaces the buffered one (newest wins); losing a code
//               that was never written to RAM raises a sticky overflow flag.
// Revision    : 1.0 - initial release
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous active-low reset
//   kb_valid  in   one-cycle pulse, new scan code on kb_code
//   kb_code   in   [7:0] scan code
//   kb_grant  in   arbiter commits kb_buf to RAM at this edge
//   kb_buf    out  [7:0] buffered scan code
//   kb_pend   out  buffered code still waiting for its RAM write
//   kb_ovf    out  sticky: a pending code was overwritten
// ============================================================================
`default_nettype none

module kb_code_latch (
    input  logic       clk,
    input  logic       reset,
    input  logic       kb_valid,
    input  logic [7:0] kb_code,
    input  logic       kb_grant,
    output logic [7:0] kb_buf,
    output logic       kb_pend,
    output logic       kb_ovf
);

    logic [7:0] r_kb_buf;
    logic       r_kb_pend;
    logic       r_kb_ovf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_kb_buf  <= 8'h00;
            r_kb_pend <= 1'b0;
            r_kb_ovf  <= 1'b0;
        end else if (kb_valid) begin
            r_kb_buf  <= kb_code;
            r_kb_pend <= 1'b1;
            // The old code is lost only if it is not being written this edge
            if (r_kb_pend && !kb_grant) begin
                r_kb_ovf <= 1'b1;
            end
        end else if (kb_grant) begin
            r_kb_pend <= 1'b0;
        end
    end

    assign kb_buf  = r_kb_buf;
    assign kb_pend = r_kb_pend;
    assign kb_ovf  = r_kb_ovf;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates the single write port of a synchronous data RAM
//               between the CPU (absolute priority, never stalled), the
//               keyboard scan-code buffer and an external requester (round
//               robin between the latter two). Tracks the worst-case
//               non-CPU grant latency and optionally snoops writes to the
//               game registers into shadow copies.
// Revision    : 1.0 - initial release
//
// Configuration macro
//   MEM_ARB_SNOOP_EN  when defined, shadow registers for words 0/2/3/5 exist;
//                     otherwise the shadow outputs are tied to zero.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   synchronous active-low reset
//   cpu_we         in   CPU store strobe
//   cpu_addr       in   [31:0] CPU byte address, word = [ADDR_W+1:2]
//   cpu_wdata      in   [31:0] CPU store data
//   kb_valid       in   one-cycle pulse, new scan code
//   kb_code        in   [7:0] scan code
//   ext_req        in   external write request, held until granted
//   ext_addr       in   [ADDR_W-1:0] external word index
//   ext_wdata      in   [31:0] external write data
//   ext_gnt        out  external write commits at this edge
//   ram_we         out  RAM write enable
//   ram_waddr      out  [ADDR_W-1:0] RAM word address
//   ram_wdata      out  [31:0] RAM write data
//   kb_ovf         out  sticky scan-code overflow
//   max_wait       out  [7:0] high-water mark of non-CPU wait cycles
//   shadow_offset  out  [31:0] copy of word 0
//   shadow_juego   out  [31:0] copy of word 2
//   shadow_end     out  bit 0 of word 3
//   shadow_coin    out  [31:0] copy of word 5
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int KB_ADDR = KB_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              kb_valid,
    input  logic [7:0]        kb_code,
    input  logic              ext_req,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_gnt,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [31:0]       ram_wdata,
    output logic              kb_ovf,
    output logic [7:0]        max_wait,
    output logic [31:0]       shadow_offset,
    output logic [31:0]       shadow_juego,
    output logic              shadow_end,
    output logic [31:0]       shadow_coin
);

    localparam logic [ADDR_W-1:0] c_kb_waddr = ADDR_W'(KB_ADDR);

    arb_src_t    w_owner;
    arb_src_t    r_rr_last;
    arb_state_t  r_state;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  r_max_wait;
    logic [7:0]  w_kb_buf;
    logic        w_kb_pend;
    logic        w_kb_grant;
    logic        w_nc_pending;
    logic        w_nc_grant;
    logic [ADDR_W-1:0] w_cpu_word;
    logic        w_unused;

    assign w_cpu_word = cpu_addr[ADDR_W+1:2];
    assign w_unused   = &{1'b0, cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    kb_code_latch u_kb_code_latch (
        .clk      (clk),
        .reset    (reset),
        .kb_valid (kb_valid),
        .kb_code  (kb_code),
        .kb_grant (w_kb_grant),
        .kb_buf   (w_kb_buf),
        .kb_pend  (w_kb_pend),
        .kb_ovf   (kb_ovf)
    );

    // Grant decision: reset masks everything, CPU wins outright, then KB/EXT
    // alternate when both are waiting.
    always_comb begin
        w_owner = SRC_NONE;
        if (!reset) begin
            w_owner = SRC_NONE;
        end else if (cpu_we) begin
            w_owner = SRC_CPU;
        end else if (w_kb_pend && ext_req) begin
            w_owner = (r_rr_last == SRC_KB) ? SRC_EXT : SRC_KB;
        end else if (w_kb_pend) begin
            w_owner = SRC_KB;
        end else if (ext_req) begin
            w_owner = SRC_EXT;
        end
    end

    // Write port follows the owner in the same cycle
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        case (w_owner)
            SRC_CPU: begin
                ram_we    = 1'b1;
                ram_waddr = w_cpu_word;
                ram_wdata = cpu_wdata;
            end
            SRC_KB: begin
                ram_we    = 1'b1;
                ram_waddr = c_kb_waddr;
                ram_wdata = {24'h0, w_kb_buf};
            end
            SRC_EXT: begin
                ram_we    = 1'b1;
                ram_waddr = ext_addr;
                ram_wdata = ext_wdata;
            end
            default: begin
                ram_we    = 1'b0;
            end
        endcase
    end

    assign w_kb_grant   = (w_owner == SRC_KB);
    assign ext_gnt      = (w_owner == SRC_EXT);
    assign w_nc_grant   = (w_owner == SRC_KB) || (w_owner == SRC_EXT);
    assign w_nc_pending = w_kb_pend || ext_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rr_last  <= SRC_EXT;
            r_wait_cnt <= 8'd0;
            r_max_wait <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (kb_valid || ext_req) begin
                        r_state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    // Leave only when nothing is left waiting after this edge
                    if (!kb_valid &&
                        (((w_owner == SRC_KB)  && !ext_req)   ||
                         ((w_owner == SRC_EXT) && !w_kb_pend) ||
                         !w_nc_pending)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_nc_grant) begin
                r_rr_last <= w_owner;
            end

            if (w_nc_grant || !w_nc_pending) begin
                r_wait_cnt <= 8'd0;
            end else if (r_wait_cnt != 8'hFF) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            if (r_wait_cnt > r_max_wait) begin
                r_max_wait <= r_wait_cnt;
            end
        end
    end

    assign max_wait = r_max_wait;

`ifdef MEM_ARB_SNOOP_EN
    logic [31:0] r_shadow_offset;
    logic [31:0] r_shadow_juego;
    logic        r_shadow_end;
    logic [31:0] r_shadow_coin;

    // Snoops the committed write, whichever source produced it
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shadow_offset <= 32'h0;
            r_shadow_juego  <= 32'h0;
            r_shadow_end    <= 1'b0;
            r_shadow_coin   <= 32'h0;
        end else if (ram_we) begin
            if (ram_waddr == ADDR_W'(OFFSET_W)) r_shadow_offset <= ram_wdata;
            if (ram_waddr == ADDR_W'(JUEGO_W))  r_shadow_juego  <= ram_wdata;
            if (ram_waddr == ADDR_W'(END_W))    r_shadow_end    <= ram_wdata[0];
            if (ram_waddr == ADDR_W'(COIN_W))   r_shadow_coin   <= ram_wdata;
        end
    end

    assign shadow_offset = r_shadow_offset;
    assign shadow_juego  = r_shadow_juego;
    assign shadow_end    = r_shadow_end;
    assign shadow_coin   = r_shadow_coin;
`else
    assign shadow_offset = 32'h0;
    assign shadow_juego  = 32'h0;
    assign shadow_end    = 1'b0;
    assign shadow_coin   = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A per-cycle vector
//               table covers reset, priority, round robin, scan-code overflow
//               and reset-while-pending; hand-written sequences cover grant
//               latency, wait-counter saturation and the shadow registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

`ifdef MEM_ARB_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        kb_valid;
    logic [7:0]  kb_code;
    logic        ext_req;
    logic [4:0]  ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic        ram_we;
    logic [4:0]  ram_waddr;
    logic [31:0] ram_wdata;
    logic        kb_ovf;
    logic [7:0]  max_wait;
    logic [31:0] shadow_offset;
    logic [31:0] shadow_juego;
    logic        shadow_end;
    logic [31:0] shadow_coin;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(5), .KB_ADDR(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .kb_valid      (kb_valid),
        .kb_code       (kb_code),
        .ext_req       (ext_req),
        .ext_addr      (ext_addr),
        .ext_wdata     (ext_wdata),
        .ext_gnt       (ext_gnt),
        .ram_we        (ram_we),
        .ram_waddr     (ram_waddr),
        .ram_wdata     (ram_wdata),
        .kb_ovf        (kb_ovf),
        .max_wait      (max_wait),
        .shadow_offset (shadow_offset),
        .shadow_juego  (shadow_juego),
        .shadow_end    (shadow_end),
        .shadow_coin   (shadow_coin)
    );

    typedef struct {
        logic        rn;
        logic        cw;
        logic [31:0] ca;
        logic [31:0] cd;
        logic        kv;
        logic [7:0]  kc;
        logic        er;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_gnt;
        logic        e_ovf;
        logic [7:0]  e_mw;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        input logic rn, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
        input logic kv, input logic [7:0] kc,
        input logic er, input logic [4:0] ea, input logic [31:0] ed,
        input logic ew, input logic [4:0] wa, input logic [31:0] wd,
        input logic eg, input logic eo, input logic [7:0] mw);
        vec_t r;
        r.rn = rn; r.cw = cw; r.ca = ca; r.cd = cd; r.kv = kv; r.kc = kc;
        r.er = er; r.ea = ea; r.ed = ed; r.e_we = ew; r.e_wa = wa; r.e_wd = wd;
        r.e_gnt = eg; r.e_ovf = eo; r.e_mw = mw;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic kv, input logic [7:0] kc,
                         input logic er, input logic [4:0] ea, input logic [31:0] ed);
        reset = rn; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        kb_valid = kv; kb_code = kc; ext_req = er; ext_addr = ea; ext_wdata = ed;
    endtask

    task automatic idle(input logic rn);
        drive(rn, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0, 5'h0, 32'h0);
    endtask

    // Inputs change at posedge+1, outputs are sampled at the negedge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_table();
        //               rn cw ca        cd            kv kc     er ea     ed            we wa     wd            gn ov mw
        tbl.push_back(v(0, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd0));
        tbl.push_back(v(0, 0, 32'h00, 32'h0,        1, 8'h55, 1, 5'd4, 32'h4,        0, 5'd0, 32'h0,        0, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        1, 8'h23, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        1, 5'd1, 32'h23,       0, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd0));
        // CPU burst holds off EXT for four cycles
        tbl.push_back(v(1, 1, 32'h0C, 32'hAABBCCDD, 0, 8'h00, 1, 5'd7, 32'h1111,     1, 5'd3, 32'hAABBCCDD, 0, 0, 8'd0));
        tbl.push_back(v(1, 1, 32'h10, 32'h2,        0, 8'h00, 1, 5'd7, 32'h1111,     1, 5'd4, 32'h2,        0, 0, 8'd0));
        tbl.push_back(v(1, 1, 32'h8C, 32'h3,        0, 8'h00, 1, 5'd7, 32'h1111,     1, 5'd3, 32'h3,        0, 0, 8'd1));
        tbl.push_back(v(1, 1, 32'h14, 32'h7,        0, 8'h00, 1, 5'd7, 32'h1111,     1, 5'd5, 32'h7,        0, 0, 8'd2));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 1, 5'd7, 32'h1111,     1, 5'd7, 32'h1111,     1, 0, 8'd3));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd4));
        // KB vs EXT after an EXT grant: KB first, then EXT
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        1, 8'h1C, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd4));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 1, 5'd9, 32'h99,       1, 5'd1, 32'h1C,       0, 0, 8'd4));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 1, 5'd9, 32'h99,       1, 5'd9, 32'h99,       1, 0, 8'd4));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd4));
        // Two codes during a CPU burst: newest wins, overflow flagged
        tbl.push_back(v(1, 1, 32'h00, 32'h5,        1, 8'h1C, 0, 5'd0, 32'h0,        1, 5'd0, 32'h5,        0, 0, 8'd4));
        tbl.push_back(v(1, 1, 32'h04, 32'h6,        1, 8'h23, 0, 5'd0, 32'h0,        1, 5'd1, 32'h6,        0, 0, 8'd4));
        tbl.push_back(v(1, 1, 32'h08, 32'h8,        0, 8'h00, 0, 5'd0, 32'h0,        1, 5'd2, 32'h8,        0, 1, 8'd4));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        1, 5'd1, 32'h23,       0, 1, 8'd4));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 8'd4));
        // New code arriving in the KB grant cycle is kept
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        1, 8'h44, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 8'd4));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        1, 8'h55, 0, 5'd0, 32'h0,        1, 5'd1, 32'h44,       0, 1, 8'd4));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        1, 5'd1, 32'h55,       0, 1, 8'd4));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 8'd4));
        // Reset while a code is pending discards it
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        1, 8'h66, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 8'd4));
        tbl.push_back(v(0, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 8'd4));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd0));
        // Back-to-back codes without CPU: no overflow
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        1, 8'h0A, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        1, 8'h0B, 0, 5'd0, 32'h0,        1, 5'd1, 32'h0A,       0, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        1, 5'd1, 32'h0B,       0, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd0));
        // From reset, KB is favoured over EXT
        tbl.push_back(v(0, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        1, 8'h77, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 1, 5'd2, 32'h22,       1, 5'd1, 32'h77,       0, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 1, 5'd2, 32'h22,       1, 5'd2, 32'h22,       1, 0, 8'd0));
        tbl.push_back(v(1, 0, 32'h00, 32'h0,        0, 8'h00, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 8'd0));
    endtask

    initial begin
        int gnt_cyc;

        idle(1'b0);
        next_cycle();
        next_cycle();

        // ---------------- table-driven vectors ----------------
        fill_table();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rn, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].kv, tbl[i].kc,
                  tbl[i].er, tbl[i].ea, tbl[i].ed);
            @(negedge clk);
            chk($sformatf("v%0d ram_we", i), {31'h0, ram_we}, {31'h0, tbl[i].e_we});
            chk($sformatf("v%0d ext_gnt", i), {31'h0, ext_gnt}, {31'h0, tbl[i].e_gnt});
            chk($sformatf("v%0d kb_ovf", i), {31'h0, kb_ovf}, {31'h0, tbl[i].e_ovf});
            chk($sformatf("v%0d max_wait", i), {24'h0, max_wait}, {24'h0, tbl[i].e_mw});
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d ram_waddr", i), {27'h0, ram_waddr}, {27'h0, tbl[i].e_wa});
                chk($sformatf("v%0d ram_wdata", i), ram_wdata, tbl[i].e_wd);
            end
            next_cycle();
        end

        // ---------------- EXT latency behind a 4-cycle CPU burst ----------------
        idle(1'b0);
        next_cycle();
        gnt_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            drive(1'b1, (c <= 4), 32'h0, 32'h0, 1'b0, 8'h0, 1'b1, 5'd6, 32'h66);
            @(negedge clk);
            if (ext_gnt) begin
                gnt_cyc = c;
                next_cycle();
                break;
            end
            next_cycle();
        end
        chk("ext grant cycle", gnt_cyc, 32'd5);
        idle(1'b1);
        @(negedge clk);
        chk("max_wait after burst", {24'h0, max_wait}, 32'd4);
        next_cycle();

        // ---------------- wait counter saturation ----------------
        idle(1'b0);
        next_cycle();
        for (int c = 0; c < 300; c++) begin
            drive(1'b1, 1'b1, 32'h40, 32'h0, 1'b0, 8'h0, 1'b1, 5'd6, 32'h66);
            next_cycle();
        end
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 1'b1, 5'd6, 32'h66);
        @(negedge clk);
        chk("ext_gnt after long burst", {31'h0, ext_gnt}, 32'd1);
        next_cycle();
        idle(1'b1);
        @(negedge clk);
        chk("max_wait saturated", {24'h0, max_wait}, 32'd255);
        next_cycle();

        // ---------------- shadow registers ----------------
        idle(1'b0);
        next_cycle();
        drive(1'b1, 1'b1, 32'h14, 32'h7, 1'b0, 8'h0, 1'b0, 5'd0, 32'h0);
        next_cycle();
        drive(1'b1, 1'b1, 32'h00, 32'h12345678, 1'b0, 8'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("shadow_coin", shadow_coin, SNOOP ? 32'h7 : 32'h0);
        next_cycle();
        drive(1'b1, 1'b1, 32'h0C, 32'hFFFF0003, 1'b0, 8'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("shadow_offset", shadow_offset, SNOOP ? 32'h12345678 : 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 1'b1, 5'd2, 32'hCAFE);
        @(negedge clk);
        chk("shadow_end", {31'h0, shadow_end}, SNOOP ? 32'h1 : 32'h0);
        next_cycle();
        idle(1'b1);
        @(negedge clk);
        chk("shadow_juego", shadow_juego, SNOOP ? 32'hCAFE : 32'h0);
        next_cycle();
        idle(1'b0);
        next_cycle();
        @(negedge clk);
        chk("shadow_coin after reset", shadow_coin, 32'h0);
        chk("shadow_offset after reset", shadow_offset, 32'h0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, sets the data-RAM word-address width (32 words).
REQ-002 Parameter KB_ADDR, default 1, is the word index that receives keyboard scan codes.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  is the synchronous, active-low reset.
REQ-005 cpu_we  input  1  is the CPU store strobe.
REQ-006 cpu_addr  input  32  is the CPU byte address; bits [ADDR_W+1:2] form the word index and the remaining bits are ignored.
REQ-007 cpu_wdata  input  32  is the CPU store data.
REQ-008 kb_valid  input  1  is a one-cycle pulse marking a new scan code.
REQ-009 kb_code  input  8  is the scan code, sampled when kb_valid=1.
REQ-010 ext_req  input  1  is the external write request, held until granted.
REQ-011 ext_addr  input  ADDR_W  is the external word index.
REQ-012 ext_wdata  input  32  is the external write data.
REQ-013 ext_gnt  output  1  is a one-cycle pulse in the cycle the external write is committed.
REQ-014 ram_we, ram_waddr[ADDR_W-1:0], ram_wdata[31:0]  output  are the shared synchronous RAM write port.
REQ-015 kb_ovf  output  1  is a sticky flag meaning a pending scan code was overwritten.
REQ-016 max_wait  output  8  is the high-water mark of non-CPU grant latency, in cycles.
REQ-017 shadow_offset[31:0], shadow_juego[31:0], shadow_end, shadow_coin[31:0]  output  are the snooped game registers.

Function
REQ-018 The RAM write port is driven combinationally from the winning source, so a write commits at the clock edge of the grant cycle.
REQ-019 Priority: cpu_we=1 grants CPU, with ram_waddr = cpu word index and ram_wdata = cpu_wdata; CPU is never stalled.
REQ-020 With cpu_we=0 and exactly one of kb_pend or ext_req set, that source is granted.
REQ-021 With cpu_we=0 and both kb_pend and ext_req set, the source not granted last is granted (round robin); rr_last updates only on KB/EXT grants.
REQ-022 With no request set, ram_we=0 and ram_waddr/ram_wdata are don't-care.
REQ-023 On kb_valid, kb_code is latched into kb_buf and kb_pend=1.
REQ-024 A KB grant writes {24'h0,kb_buf} to KB_ADDR and clears kb_pend at the edge.
REQ-025 kb_valid in the same cycle as a KB grant latches the new code and keeps kb_pend=1; kb_ovf is not set.
REQ-026 kb_valid while kb_pend=1 and no KB grant overwrites kb_buf (newest code wins) and sets kb_ovf.
REQ-027 ext_gnt=1 in exactly the grant cycle. A requester that keeps ext_req high in the next cycle presents a new write.
REQ-028 wait_cnt counts consecutive cycles in which kb_pend or ext_req is set but ungranted.
REQ-029 wait_cnt clears on any KB/EXT grant and saturates at 255.
REQ-030 max_wait takes the value of wait_cnt whenever wait_cnt exceeds max_wait.
REQ-031 States: IDLE (no pending), PEND (non-CPU pending), with grant owner in {NONE,CPU,KB,EXT}.
REQ-032 IDLE moves to PEND on kb_valid or ext_req; PEND returns to IDLE when the last pending source is granted with none new.

Reset
REQ-033 While reset=0 at an edge: kb_pend=0, kb_buf=0, kb_ovf=0, rr_last=EXT (KB favoured first), wait_cnt=0, max_wait=0, all shadows=0.
REQ-034 While reset=0, ram_we=0 and ext_gnt=0 combinationally, and kb_valid is ignored.
REQ-035 Reset asserted mid-pending discards the pending code without writing it.

Configuration
REQ-036 With MEM_ARB_SNOOP_EN defined, every committed write to word 0/2/3/5 updates shadow_offset, shadow_juego, shadow_end (bit 0) or shadow_coin respectively, visible the cycle after commit.
REQ-037 Without MEM_ARB_SNOOP_EN, all shadow outputs are tied 0 and no shadow flops exist.

Structure
REQ-038 Package mem_arb_pkg holds the word constants (OFFSET_W=0, KB_W=1, JUEGO_W=2, END_W=3, COIN_W=5) and enum arb_src_t {SRC_NONE,SRC_CPU,SRC_KB,SRC_EXT}.
REQ-039 Sub-module kb_code_latch implements kb_buf, kb_pend and kb_ovf (REQ-023..026); arbitration and snooping stay in the top.

Verification
REQ-040 kb_valid with code 8'h23, CPU idle -> next cycle ram_we=1, ram_waddr=1, ram_wdata=32'h23; kb_pend then 0.
REQ-041 cpu_we held 4 cycles while ext_req=1 -> ext_gnt in cycle 5; max_wait=4.
REQ-042 kb_pend and ext_req both set, CPU idle, from reset -> grants KB then EXT on consecutive cycles.
REQ-043 kb_valid 8'h1C then 8'h23 during a CPU store burst -> single write of 32'h23 to word 1; kb_ovf=1.
REQ-044 With MEM_ARB_SNOOP_EN, CPU store 32'h7 to byte address 0x14 -> shadow_coin=7 the next cycle; reset -> 0.
REQ-045 reset=0 asserted with kb_pend=1 -> no RAM write occurs; kb_ovf=0 and max_wait=0 afterwards.
